// File: rtl/multi_edge_filter_pkg.sv
// Shared definitions for the multi-channel edge filter: event-select encodings
// and the sizing helper for the per-channel glitch-filter counter.
package multi_edge_filter_pkg;

  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/multi_edge_filter_if.sv
// Bundle of the per-channel trigger inputs, controls and event outputs.
// master drives the trigger lines and controls, slave is the filter block.
interface multi_edge_filter_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 16
);
  logic [CH-1:0]       pulse_in;
  logic [2*CH-1:0]     mode;
  logic [CH-1:0]       flag_clr;
  logic                cnt_clr;
  logic [CH-1:0]       level;
  logic [CH-1:0]       rise;
  logic [CH-1:0]       fall;
  logic [CH-1:0]       evt;
  logic [CH-1:0]       evt_flag;
  logic [CH*CNT_W-1:0] evt_cnt;

  modport master (
    output pulse_in, mode, flag_clr, cnt_clr,
    input  level, rise, fall, evt, evt_flag, evt_cnt
  );

  modport slave (
    input  pulse_in, mode, flag_clr, cnt_clr,
    output level, rise, fall, evt, evt_flag, evt_cnt
  );
endinterface

// File: rtl/edge_filter_chan.sv
// One trigger channel: synchroniser, persistence filter, registered rise/fall/evt
// strobes, sticky event flag and saturating event counter.
module edge_filter_chan
  import multi_edge_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pulse,
  input  logic [1:0]       i_mode,
  input  logic             i_flag_clr,
  input  logic             i_cnt_clr,
  output logic             o_level,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_evt,
  output logic             o_evt_flag,
  output logic [CNT_W-1:0] o_evt_cnt
);
  localparam int              FC_W    = clog2(FILT_LEN) + 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [FC_W-1:0]        r_fc;
  logic                   r_level, r_rise, r_fall, r_evt, r_flag;
  logic [CNT_W-1:0]       r_cnt;

  logic w_s, w_update, w_rise_nxt, w_fall_nxt, w_rise_sel, w_fall_sel;

  assign w_s        = r_sync[SYNC_STAGES-1];
  // Level only moves once the mismatch has persisted for FILT_LEN cycles
  assign w_update   = (w_s != r_level) && (r_fc == FC_LAST);
  assign w_rise_nxt = w_update & w_s;
  assign w_fall_nxt = w_update & ~w_s;

  always_comb begin
    w_rise_sel = 1'b0;
    w_fall_sel = 1'b0;
    case (i_mode)
      EDGE_NONE: ;
      EDGE_RISE: w_rise_sel = 1'b1;
      EDGE_FALL: w_fall_sel = 1'b1;
      EDGE_BOTH: begin w_rise_sel = 1'b1; w_fall_sel = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_pulse};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fc    <= '0;
      r_level <= 1'b0;
    end else if (w_s == r_level) begin
      r_fc    <= '0;
    end else if (w_update) begin
      r_fc    <= '0;
      r_level <= w_s;
    end else begin
      r_fc    <= r_fc + FC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_evt  <= 1'b0;
    end else begin
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      r_evt  <= (w_rise_nxt & w_rise_sel) | (w_fall_nxt & w_fall_sel);
    end
  end

  // Set has priority over clear so a coincident event is never lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_flag <= 1'b0;
    else     r_flag <= r_evt | (r_flag & ~i_flag_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_cnt <= '0;
    else if (i_cnt_clr)                 r_cnt <= '0;
    else if (r_evt && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_level    = r_level;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_evt      = r_evt;
  assign o_evt_flag = r_flag;
  assign o_evt_cnt  = r_cnt;

endmodule

// File: rtl/multi_edge_filter.sv
// CH independent trigger/gate channels; packs per-channel mode and counter
// slices onto the shared bus.
module multi_edge_filter
  import multi_edge_filter_pkg::*;
#(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  multi_edge_filter_if.slave bus
);
  logic [CH-1:0]            w_level, w_rise, w_fall, w_evt, w_flag;
  logic [CH-1:0][CNT_W-1:0] w_cnt;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    edge_filter_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN),
      .CNT_W      (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_pulse   (bus.pulse_in[g]),
      .i_mode    (bus.mode[2*g +: 2]),
      .i_flag_clr(bus.flag_clr[g]),
      .i_cnt_clr (bus.cnt_clr),
      .o_level   (w_level[g]),
      .o_rise    (w_rise[g]),
      .o_fall    (w_fall[g]),
      .o_evt     (w_evt[g]),
      .o_evt_flag(w_flag[g]),
      .o_evt_cnt (w_cnt[g])
    );
  end

  assign bus.level    = w_level;
  assign bus.rise     = w_rise;
  assign bus.fall     = w_fall;
  assign bus.evt      = w_evt;
  assign bus.evt_flag = w_flag;
  assign bus.evt_cnt  = w_cnt;

endmodule

// File: tb/tb_multi_edge_filter.sv
// Two instances: A with legacy timing (2 sync, no filter, 16-bit counters),
// B with 3 sync, FILT_LEN=4 and 3-bit counters. Strobes are scoreboarded.
module tb_multi_edge_filter;
  import multi_edge_filter_pkg::*;

  localparam int CH = 4;
  localparam int SA = 2, FA = 1, WA = 16, LAT_A = SA + FA;
  localparam int SB = 3, FB = 4, WB = 3,  LAT_B = SB + FB;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   cyc = 0, n_chk = 0, n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_edge_filter_if #(.CH(CH), .CNT_W(WA)) bus_a();
  multi_edge_filter_if #(.CH(CH), .CNT_W(WB)) bus_b();

  multi_edge_filter #(.CH(CH), .SYNC_STAGES(SA), .FILT_LEN(FA), .CNT_W(WA)) dut_a (
    .clk(clk), .rst(rst_a), .bus(bus_a));
  multi_edge_filter #(.CH(CH), .SYNC_STAGES(SB), .FILT_LEN(FB), .CNT_W(WB)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b));

  typedef struct {
    int            t;
    logic [CH-1:0] r, f, e;
  } exp_t;

  exp_t qa[$], qb[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Expected strobe set at cycle t; evt derived from the mode currently driven
  task automatic push(input bit d, input int t, input logic [CH-1:0] r, input logic [CH-1:0] f);
    exp_t e;
    logic [2*CH-1:0] m;
    bit done;
    if ((r | f) == '0) return;
    m = d ? bus_b.mode : bus_a.mode;
    e.t = t; e.r = r; e.f = f; e.e = '0;
    for (int c = 0; c < CH; c++) e.e[c] = (r[c] & m[2*c]) | (f[c] & m[2*c+1]);
    done = 0;
    if (!d) begin
      for (int k = 0; k < qa.size() && !done; k++)
        if (qa[k].t == t) begin
          qa[k].r |= r; qa[k].f |= f; qa[k].e |= e.e; done = 1;
        end else if (qa[k].t > t) begin
          qa.insert(k, e); done = 1;
        end
      if (!done) qa.push_back(e);
    end else begin
      for (int k = 0; k < qb.size() && !done; k++)
        if (qb[k].t == t) begin
          qb[k].r |= r; qb[k].f |= f; qb[k].e |= e.e; done = 1;
        end else if (qb[k].t > t) begin
          qb.insert(k, e); done = 1;
        end
      if (!done) qb.push_back(e);
    end
  endtask

  // Drive the masked channels to v; ex=1 when the run is long enough to pass the filter
  task automatic tog(input bit d, input logic [CH-1:0] msk, input logic v, input bit ex);
    if (!d) bus_a.pulse_in = v ? (bus_a.pulse_in | msk) : (bus_a.pulse_in & ~msk);
    else    bus_b.pulse_in = v ? (bus_b.pulse_in | msk) : (bus_b.pulse_in & ~msk);
    if (ex) push(d, cyc + (d ? LAT_B : LAT_A), v ? msk : '0, v ? '0 : msk);
  endtask

  // Reset release: level restarts at 0, so inputs already high report a rise
  task automatic rel(input bit d);
    if (!d) begin rst_a = 1'b0; push(0, cyc + LAT_A, bus_a.pulse_in, '0); end
    else    begin rst_b = 1'b0; push(1, cyc + LAT_B, bus_b.pulse_in, '0); end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if ((bus_a.rise | bus_a.fall | bus_a.evt) != '0) begin
      if (qa.size() == 0)
        chk("a_unexpected_strobe", {bus_a.rise, bus_a.fall, bus_a.evt}, 0);
      else begin
        e = qa.pop_front();
        chk("a_strobe_cycle", cyc, e.t);
        chk("a_rise", bus_a.rise, e.r);
        chk("a_fall", bus_a.fall, e.f);
        chk("a_evt",  bus_a.evt,  e.e);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if ((bus_b.rise | bus_b.fall | bus_b.evt) != '0) begin
      if (qb.size() == 0)
        chk("b_unexpected_strobe", {bus_b.rise, bus_b.fall, bus_b.evt}, 0);
      else begin
        e = qb.pop_front();
        chk("b_strobe_cycle", cyc, e.t);
        chk("b_rise", bus_b.rise, e.r);
        chk("b_fall", bus_b.fall, e.f);
        chk("b_evt",  bus_b.evt,  e.e);
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.pulse_in = '0; bus_a.mode = '0; bus_a.flag_clr = '0; bus_a.cnt_clr = 1'b0;
    bus_b.pulse_in = '0; bus_b.mode = '0; bus_b.flag_clr = '0; bus_b.cnt_clr = 1'b0;
    step(3);
    chk("rst_level", bus_a.level, 0);
    chk("rst_strobes", {bus_a.rise, bus_a.fall, bus_a.evt}, 0);
    chk("rst_flag", bus_a.evt_flag, 0);
    chk("rst_cnt_a", bus_a.evt_cnt, 0);
    chk("rst_cnt_b", bus_b.evt_cnt, 0);
    rel(0); rel(1);
    step(4);

    // Legacy latency: rise and fall on ch0, nothing elsewhere
    tog(0, 4'b0001, 1'b1, 1'b1);
    step(LAT_A - 1);
    chk("t1_level_before", bus_a.level, 0);
    step(1);
    chk("t1_level_after", bus_a.level, 4'b0001);
    step(4);
    tog(0, 4'b0001, 1'b0, 1'b1);
    step(LAT_A + 2);
    chk("t1_level_low", bus_a.level, 0);
    chk("t1_cnt_mode_none", bus_a.evt_cnt[0 +: WA], 0);

    // Rise-only events on ch1, flag and counter
    bus_a.mode = {2'b00, 2'b00, EDGE_RISE, 2'b00};
    repeat (3) begin
      tog(0, 4'b0010, 1'b1, 1'b1); step(3);
      tog(0, 4'b0010, 1'b0, 1'b1); step(3);
    end
    step(LAT_A + 2);
    chk("t3_cnt3", bus_a.evt_cnt[WA +: WA], 3);
    chk("t3_flag", bus_a.evt_flag, 4'b0010);
    bus_a.flag_clr[1] = 1'b1; step(1); bus_a.flag_clr[1] = 1'b0;
    chk("t3_flag_cleared", bus_a.evt_flag[1], 0);
    tog(0, 4'b0010, 1'b1, 1'b1);
    step(LAT_A);
    chk("t3_evt4", bus_a.evt[1], 1);
    bus_a.flag_clr[1] = 1'b1; step(1); bus_a.flag_clr[1] = 1'b0;
    chk("t3_flag_kept", bus_a.evt_flag[1], 1);
    chk("t3_cnt4", bus_a.evt_cnt[WA +: WA], 4);
    tog(0, 4'b0010, 1'b0, 1'b1);
    step(LAT_A + 2);

    // All channels at once
    bus_a.mode = {4{EDGE_BOTH}};
    tog(0, 4'b1111, 1'b1, 1'b1);
    step(LAT_A + 2);
    chk("t_all_level", bus_a.level, 4'b1111);
    chk("t_all_flag", bus_a.evt_flag, 4'b1111);
    chk("t_all_cnt2", bus_a.evt_cnt[2*WA +: WA], 1);

    // Reset with inputs held high: one rise per channel after release
    rst_a = 1'b1; #1;
    chk("t5_rst_level", bus_a.level, 0);
    chk("t5_rst_flag", bus_a.evt_flag, 0);
    chk("t5_rst_cnt1", bus_a.evt_cnt[WA +: WA], 0);
    step(2);
    rel(0);
    step(LAT_A - 1);
    chk("t5_level_before", bus_a.level, 0);
    step(4);
    chk("t5_level_after", bus_a.level, 4'b1111);

    // Filtered instance: 3-cycle glitch rejected, 4-cycle pulse passes
    tog(1, 4'b0001, 1'b1, 1'b0); step(3);
    tog(1, 4'b0001, 1'b0, 1'b0); step(LAT_B + 4);
    chk("t2_glitch_level", bus_b.level, 0);
    tog(1, 4'b0001, 1'b1, 1'b1); step(4);
    tog(1, 4'b0001, 1'b0, 1'b1);
    step(LAT_B - 4 - 1);
    chk("t2_level_before", bus_b.level, 0);
    step(1);
    chk("t2_level_high", bus_b.level, 4'b0001);
    step(LAT_B);
    chk("t2_level_low", bus_b.level, 0);

    // Saturating 3-bit counter on ch3, then clear and clear-vs-increment
    bus_b.mode = {EDGE_BOTH, 6'b0};
    for (int i = 0; i < 9; i++) begin
      tog(1, 4'b1000, (i % 2 == 0), 1'b1); step(5);
    end
    step(LAT_B + 2);
    chk("t4_cnt_sat", bus_b.evt_cnt[3*WB +: WB], 7);
    bus_b.cnt_clr = 1'b1; step(1); bus_b.cnt_clr = 1'b0;
    chk("t4_cnt_clr", bus_b.evt_cnt[3*WB +: WB], 0);
    tog(1, 4'b1000, 1'b0, 1'b1);
    step(LAT_B + 1);
    chk("t4_cnt1", bus_b.evt_cnt[3*WB +: WB], 1);
    step(3);
    tog(1, 4'b1000, 1'b1, 1'b1);
    step(LAT_B);
    chk("t4_evt_pre_clr", bus_b.evt[3], 1);
    bus_b.cnt_clr = 1'b1; step(1); bus_b.cnt_clr = 1'b0;
    chk("t4_clr_wins", bus_b.evt_cnt[3*WB +: WB], 0);
    step(1);
    chk("t4_clr_stays", bus_b.evt_cnt[3*WB +: WB], 0);
    step(2);

    // Reset two cycles into ch2's filter run: no strobe, fresh rise after release
    tog(1, 4'b0100, 1'b1, 1'b0);
    step(5);
    rst_b = 1'b1; #1;
    chk("t6_rst_level", bus_b.level, 0);
    chk("t6_rst_flag", bus_b.evt_flag, 0);
    step(2);
    rel(1);
    step(LAT_B - 1);
    chk("t6_level_before", bus_b.level, 0);
    step(1);
    chk("t6_level_after", bus_b.level, 4'b1100);
    step(3);
    chk("t6_cnt3", bus_b.evt_cnt[3*WB +: WB], 1);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multi_edge_filter.md
Name: multi_edge_filter

Overview:
Parametrised successor to the team's single-channel wide-pulse rise/fall generator. Handles CH asynchronous level inputs per instance. Each channel gets:
- a configurable-depth synchroniser
- a glitch filter
- rise/fall strobes
- a mode-selected event strobe, a sticky event flag and a saturating event counter
Sits between external trigger/gate lines and the radar timing/control logic.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_LEN, 1, consecutive agreeing cycles required before the filtered level changes (>=1; 1 = no filtering)
CNT_W, 16, per-channel event counter width (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
pulse_in  in  CH  asynchronous level inputs, bit i = channel i
mode  in  2*CH  per-channel event select, bits [2i+1:2i]: 00 none, 01 rise, 10 fall, 11 both
flag_clr  in  CH  per-channel sticky-flag clear, synchronous to clk
cnt_clr  in  1  clears all event counters, synchronous to clk
level  out  CH  filtered, synchronised level
rise  out  CH  1-cycle strobe on filtered 0->1
fall  out  CH  1-cycle strobe on filtered 1->0
evt  out  CH  1-cycle strobe = (rise & mode rise-bit) | (fall & mode fall-bit)
evt_flag  out  CH  sticky: set by evt, cleared by flag_clr
evt_cnt  out  CH*CNT_W  per-channel evt count, channel i at [(i+1)*CNT_W-1 : i*CNT_W]

Behaviour:
- Reset (async assert, released on clk domain): all sync flops, filter counters, level, rise, fall, evt, evt_flag and evt_cnt are 0.
- Synchroniser: pulse_in[i] passes through SYNC_STAGES flops; the last stage is s[i]. Only s[i] is used downstream.
- Filter: per channel, counter fc of width clog2(FILT_LEN)+1.
  - If s != level: fc increments each cycle. On the cycle fc == FILT_LEN-1, level <= s and fc <= 0.
  - If s == level: fc <= 0. Any mismatch run shorter than FILT_LEN cycles is discarded.
- Strobes: rise/fall are registered and assert in the same edge that level updates (rise if new level is 1, fall if 0). They are high exactly 1 cycle. Rise and fall are never both high on the same channel.
- Latency: input sampled new at edge k gives the rise/fall/level update after edge k+SYNC_STAGES+FILT_LEN-1. With SYNC_STAGES=2, FILT_LEN=1 this equals legacy generator timing (k+2).
- Minimum resolvable pulse: FILT_LEN cycles at s. Back-to-back opposite edges spaced >= FILT_LEN cycles each produce a strobe.
- evt: registered together with rise/fall, i.e. same cycle, using mode sampled in the same cycle as the level update. Mode changes affect evt only; rise/fall/level are unaffected.
- evt_flag[i]: set on evt[i]. Cleared by flag_clr[i] the next edge. Simultaneous evt and flag_clr: flag stays/sets 1 (no lost events).
- evt_cnt[i]: increments by 1 one cycle after evt[i] (counter update registered off the evt register) and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr zeroes all counters next edge.
  - cnt_clr coincident with an increment: clear wins, result 0.
- Input high at reset release: level starts 0, so a rise is reported after normal latency. This is intentional (reports initial state).
- Reset asserted mid-filter or mid-strobe: all state returns to 0 immediately. No strobe is emitted for the interrupted edge.
- Channels are fully independent; simultaneous events on all channels are all reported.

Decomposition:
- Shared package: mode encoding constants EDGE_NONE=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11, and a clog2 function for filter counter sizing.
- Sub-module edge_filter_chan: one channel's synchroniser, filter, rise/fall/evt, flag and counter. Same parameters minus CH.
- Top instantiates CH copies in a generate loop and handles slice packing of mode/evt_cnt.

Test Plan:
1. Defaults, CH=4: pulse_in[0] 0->1 sampled at edge 10 -> level[0]=1 and rise[0]=1 for one cycle after edge 12. Later 1->0 gives fall[0] 1 cycle at same latency. Other channels stay 0.
2. FILT_LEN=4, SYNC_STAGES=3: 3-cycle high glitch -> no level change, no strobes. 4-cycle pulse -> rise after edge k+6, then fall 4 cycles later.
3. mode=01 on ch1, ch1 toggled 3 times high/low -> evt[1] pulses 3 times (rises only), evt_cnt[1]=3, evt_flag[1]=1. flag_clr[1] on same cycle as a 4th evt -> flag remains 1.
4. CNT_W=3, 9 events with mode=11 -> evt_cnt saturates at 7. cnt_clr coincident with an increment -> 0 next cycle.
5. pulse_in all 1 during reset, release rst -> every channel reports rise exactly once, with latency SYNC_STAGES+FILT_LEN-1 after first sampling edge.
6. Assert rst while ch2 filter is mid-count (FILT_LEN=4, 2 cycles in) -> all outputs 0 immediately. Input still high after release -> fresh rise after full latency.
